// File: rtl/emu_fetch_sequencer.sv
// Fetch/issue sequencer for the Thumb-subset emulator: one-word fetch buffer,
// BL pair joining, PC ownership, branch redirect and halt.
module emu_fetch_sequencer #(
  parameter int              ADDR_W   = 10,
  parameter logic [ADDR_W:0] RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              instr_valid,
  output logic [31:0]       instr,
  output logic              instr_wide,
  output logic [ADDR_W:0]   pc,
  input  logic              exec_done,
  input  logic              branch_taken,
  input  logic [ADDR_W:0]   branch_target,
  input  logic              halt_req,
  output logic              halted,
  output logic [31:0]       retired
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    FETCH2,
    ISSUE,
    HALT
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [31:0]       buf_word;
  logic [ADDR_W-1:0] buf_addr;
  logic              buf_valid;

  logic [ADDR_W-1:0] pc_word;
  logic [ADDR_W-1:0] next_word;
  logic [ADDR_W:0]   pc_step;
  logic              hit;
  logic [31:0]       src;
  logic [15:0]       hw;
  logic              prefix;
  logic              fetch_take;
  logic              suffix_take;
  logic              retire;

  assign pc_word   = pc[ADDR_W:1];
  assign next_word = pc_word + {{(ADDR_W-1){1'b0}}, 1'b1};
  assign pc_step   = {{(ADDR_W-1){1'b0}}, instr_wide, ~instr_wide};

  assign hit    = buf_valid && (buf_addr == pc_word);
  assign src    = hit ? buf_word : mem_rdata;
  assign hw     = pc[0] ? src[31:16] : src[15:0];
  assign prefix = (hw[15:11] == 5'b11110);

  assign instr_valid = (state_q == ISSUE);
  assign halted      = (state_q == HALT);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    mem_req     = 1'b0;
    mem_addr    = pc_word;
    fetch_take  = 1'b0;
    suffix_take = 1'b0;
    retire      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = FETCH;
      end
      FETCH: begin
        mem_req = !hit;
        if (hit || mem_ack) begin
          fetch_take = 1'b1;
          state_d    = (prefix && pc[0]) ? FETCH2 : ISSUE;
        end
      end
      FETCH2: begin
        mem_req  = 1'b1;
        mem_addr = next_word;
        if (mem_ack) begin
          suffix_take = 1'b1;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (exec_done) begin
          retire  = 1'b1;
          state_d = halt_req ? HALT : FETCH;
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc         <= RESET_PC;
      instr      <= '0;
      instr_wide <= 1'b0;
      retired    <= '0;
      buf_word   <= '0;
      buf_addr   <= '0;
      buf_valid  <= 1'b0;
    end else begin
      if (fetch_take) begin
        if (!hit) begin
          buf_word  <= mem_rdata;
          buf_addr  <= pc_word;
          buf_valid <= 1'b1;
        end
        instr_wide <= prefix && !pc[0];
        if (!prefix) begin
          instr <= {16'h0, hw};
        end else if (!pc[0]) begin
          instr <= {hw, src[31:16]};
        end else begin
          instr <= {hw, 16'h0};
        end
      end
      // Suffix of a BL that straddles a word: refill with the next word
      if (suffix_take) begin
        buf_word    <= mem_rdata;
        buf_addr    <= next_word;
        buf_valid   <= 1'b1;
        instr[15:0] <= mem_rdata[15:0];
        instr_wide  <= 1'b1;
      end
      if (retire) begin
        retired <= retired + 32'd1;
        if (!halt_req) begin
          if (branch_taken) begin
            pc        <= branch_target;
            buf_valid <= 1'b0;
          end else begin
            pc <= pc + pc_step;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_emu_fetch_sequencer.sv
// Bench for emu_fetch_sequencer: decode vector table, directed corner
// sequences and a random program run against a halfword-level model.
module tb_emu_fetch_sequencer;

  localparam int AW = 10;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack;
  logic [31:0]   mem_rdata;
  logic          instr_valid;
  logic [31:0]   instr;
  logic          instr_wide;
  logic [AW:0]   pc;
  logic          exec_done = 1'b0;
  logic          branch_taken = 1'b0;
  logic [AW:0]   branch_target = '0;
  logic          halt_req = 1'b0;
  logic          halted;
  logic [31:0]   retired;

  emu_fetch_sequencer #(.ADDR_W(AW), .RESET_PC('0)) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .mem_req(mem_req),
    .mem_addr(mem_addr),
    .mem_ack(mem_ack),
    .mem_rdata(mem_rdata),
    .instr_valid(instr_valid),
    .instr(instr),
    .instr_wide(instr_wide),
    .pc(pc),
    .exec_done(exec_done),
    .branch_taken(branch_taken),
    .branch_target(branch_target),
    .halt_req(halt_req),
    .halted(halted),
    .retired(retired)
  );

  always #5 clock = ~clock;

  logic [31:0] mem [0:1023];

  logic        resp_ack = 1'b0;
  logic [31:0] resp_data = '0;
  logic        man_ack = 1'b0;
  logic [31:0] man_data = '0;
  logic        mem_en = 1'b1;
  int          lat = 0;
  bit          rand_lat = 1'b0;

  assign mem_ack   = man_ack | (mem_en & resp_ack);
  assign mem_rdata = man_ack ? man_data : resp_data;

  int          wait_cnt = 0;
  int          cur_lat = 0;
  bit          prev_req = 1'b0;
  bit          prev_ack = 1'b0;
  logic [9:0]  held_addr = '0;
  logic [9:0]  last_addr = '0;
  int          req_cnt = 0;
  int          addr_bad = 0;
  int          excl_bad = 0;

  // Memory responder and handshake monitor
  always @(negedge clock) begin
    resp_ack = 1'b0;
    if (mem_req && mem_en) begin
      if (!prev_req || prev_ack) begin
        req_cnt++;
        last_addr = mem_addr;
        held_addr = mem_addr;
        wait_cnt  = 0;
        cur_lat   = rand_lat ? int'($urandom_range(0, 3)) : lat;
      end else if (mem_addr !== held_addr) begin
        addr_bad++;
      end
      if (wait_cnt >= cur_lat) begin
        resp_ack  = 1'b1;
        resp_data = mem[mem_addr];
      end else begin
        wait_cnt++;
      end
    end
    prev_req = mem_req;
    prev_ack = resp_ack;
    if (mem_req && instr_valid) excl_bad++;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic wait_issue(input string nm);
    int n;
    n = 0;
    while (!instr_valid && n < 60) begin
      tick(1);
      n++;
    end
    if (!instr_valid) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: instr_valid timeout got 0 expected 1", nm);
    end
  endtask

  task automatic do_exec(input bit br, input logic [AW:0] tgt,
                         input bit hlt);
    exec_done     = 1'b1;
    branch_taken  = br;
    branch_target = tgt;
    halt_req      = hlt;
    tick(1);
    exec_done    = 1'b0;
    branch_taken = 1'b0;
    halt_req     = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    start     = 1'b0;
    exec_done = 1'b0;
    halt_req  = 1'b0;
    man_ack   = 1'b0;
    mem_en    = 1'b1;
    lat       = 0;
    rand_lat  = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(1);
  endtask

  function automatic logic [15:0] half(input logic [AW:0] p);
    logic [31:0] w;
    w = mem[p[AW:1]];
    return p[0] ? w[31:16] : w[15:0];
  endfunction

  typedef struct {
    logic [AW:0] vpc;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] exp_instr;
    logic        exp_wide;
    logic [AW:0] exp_next;
  } vec_t;

  vec_t vt[9];

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int base;
    logic [AW:0] exp_pc;
    logic [31:0] exp_ret;
    logic [15:0] h;
    logic [31:0] ei;
    logic        ew;
    logic [9:0]  wa;
    logic [9:0]  wb;

    vt[0] = '{11'h004, 32'h3001_2002, 32'h0, 32'h0000_2002, 1'b0, 11'h005};
    vt[1] = '{11'h005, 32'h3001_2002, 32'h0, 32'h0000_3001, 1'b0, 11'h006};
    vt[2] = '{11'h006, 32'hF800_F123, 32'h0, 32'hF123_F800, 1'b1, 11'h008};
    vt[3] = '{11'h007, 32'hF456_0000, 32'h0000_F900, 32'hF456_F900,
              1'b1, 11'h009};
    vt[4] = '{11'h008, 32'h1234_F8AB, 32'h0, 32'h0000_F8AB, 1'b0, 11'h009};
    vt[5] = '{11'h7FF, 32'hF7FF_0000, 32'h0000_FFFF, 32'hF7FF_FFFF,
              1'b1, 11'h001};
    vt[6] = '{11'h7FE, 32'hBEEF_4770, 32'h0, 32'h0000_4770, 1'b0, 11'h7FF};
    vt[7] = '{11'h7FF, 32'h4770_0000, 32'h0, 32'h0000_4770, 1'b0, 11'h000};
    vt[8] = '{11'h010, 32'h0000_E7FE, 32'h0, 32'h0000_E7FE, 1'b0, 11'h011};

    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;

    // Reset state
    do_reset();
    check("rst_mem_req", mem_req, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_instr", instr, 0);
    check("rst_wide", instr_wide, 0);
    check("rst_halted", halted, 0);
    check("rst_retired", retired, 0);
    check("rst_pc", pc, 0);

    // Sequential hit
    mem[0] = 32'h3001_2002;
    base = req_cnt;
    pulse_start();
    wait_issue("t1_issue0");
    check("t1_instr0", instr, 32'h2002);
    check("t1_pc0", pc, 0);
    do_exec(0, '0, 0);
    check("t1_gap_valid", instr_valid, 0);
    check("t1_hit_noreq", mem_req, 0);
    tick(1);
    check("t1_issue1_valid", instr_valid, 1);
    check("t1_instr1", instr, 32'h3001);
    check("t1_pc1", pc, 1);
    check("t1_reqs", req_cnt - base, 1);
    check("t1_addr", last_addr, 0);
    do_exec(0, '0, 0);
    check("t1_retired", retired, 2);
    check("t1_pc2", pc, 2);

    // Ack latency
    do_reset();
    mem[0] = 32'h1111_2222;
    lat = 5;
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      check("t2_req_held", mem_req, 1);
      check("t2_addr_held", mem_addr, 0);
      check("t2_no_valid", instr_valid, 0);
      tick(1);
    end
    check("t2_ack_cycle_valid", instr_valid, 0);
    tick(1);
    check("t2_capture_valid", instr_valid, 1);
    check("t2_capture_instr", instr, 32'h2222);

    // BL across a word boundary
    do_reset();
    mem[0] = 32'h0;
    mem[1] = 32'hF000_0000;
    mem[2] = 32'h0000_F800;
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      wait_issue("t3_nop");
      do_exec(0, '0, 0);
    end
    wait_issue("t3_bl");
    check("t3_fetch2_addr", last_addr, 2);
    check("t3_instr", instr, 32'hF000_F800);
    check("t3_wide", instr_wide, 1);
    check("t3_pc", pc, 3);
    do_exec(0, '0, 0);
    check("t3_pc_next", pc, 5);

    // Branch redirect invalidates the buffer, then halt priority
    do_reset();
    mem[0] = 32'h1111_2222;
    mem[8] = 32'h3333_4444;
    pulse_start();
    wait_issue("t4_issue0");
    base = req_cnt;
    do_exec(1, 11'h001, 0);
    wait_issue("t4_same_word");
    check("t4_refetch", req_cnt - base, 1);
    check("t4_instr_same", instr, 32'h1111);
    check("t4_pc_same", pc, 1);
    do_exec(1, 11'h010, 0);
    check("t4_pc_tgt", pc, 11'h010);
    check("t4_req", mem_req, 1);
    check("t4_addr", mem_addr, 8);
    wait_issue("t4_tgt");
    check("t4_instr_tgt", instr, 32'h4444);
    do_exec(1, 11'h020, 1);
    check("t5_halted", halted, 1);
    check("t5_pc", pc, 11'h010);
    check("t5_retired", retired, 3);
    check("t5_valid", instr_valid, 0);
    base = req_cnt;
    pulse_start();
    tick(4);
    check("t5_start_ignored", req_cnt - base, 0);
    check("t5_still_halted", halted, 1);

    // Reset mid-fetch, late ack, then PC wrap
    do_reset();
    mem[0] = 32'h0000_1234;
    lat = 10;
    pulse_start();
    tick(3);
    check("t6_req_before", mem_req, 1);
    reset = 1'b1;
    #2;
    check("t6_async_req", mem_req, 0);
    check("t6_async_pc", pc, 0);
    tick(1);
    reset  = 1'b0;
    mem_en = 1'b0;
    man_data = 32'hDEAD_BEEF;
    man_ack  = 1'b1;
    tick(2);
    man_ack = 1'b0;
    check("t6_late_req", mem_req, 0);
    check("t6_late_valid", instr_valid, 0);
    mem_en = 1'b1;
    lat = 0;
    pulse_start();
    wait_issue("t6_issue");
    check("t6_instr", instr, 32'h1234);
    mem[1023] = 32'h4770_0000;
    do_exec(1, 11'h7FF, 0);
    wait_issue("t6_top");
    check("t6_top_instr", instr, 32'h4770);
    do_exec(0, '0, 0);
    check("t6_wrap_pc", pc, 0);
    check("t6_wrap_req", mem_req, 1);
    check("t6_wrap_addr", mem_addr, 0);

    // Decode vector table
    for (int i = 0; i < 9; i++) begin
      do_reset();
      wa = vt[i].vpc[AW:1];
      wb = wa + 10'd1;
      mem[wa] = vt[i].w0;
      mem[wb] = vt[i].w1;
      pulse_start();
      wait_issue("vec_first");
      do_exec(1, vt[i].vpc, 0);
      wait_issue("vec_issue");
      check($sformatf("vec%0d_instr", i), instr, vt[i].exp_instr);
      check($sformatf("vec%0d_wide", i), instr_wide, vt[i].exp_wide);
      check($sformatf("vec%0d_pc", i), pc, vt[i].vpc);
      do_exec(0, '0, 0);
      check($sformatf("vec%0d_next", i), pc, vt[i].exp_next);
    end

    // Random program against the halfword-level model
    for (int i = 0; i < 1024; i++) begin
      logic [15:0] a;
      logic [15:0] b;
      a = ($urandom_range(0, 3) == 0) ? {5'b11110, 11'($urandom)}
                                      : 16'($urandom);
      b = ($urandom_range(0, 3) == 0) ? {5'b11110, 11'($urandom)}
                                      : 16'($urandom);
      mem[i] = {b, a};
    end
    do_reset();
    rand_lat = 1'b1;
    exp_pc  = '0;
    exp_ret = '0;
    pulse_start();
    for (int k = 0; k < 200; k++) begin
      bit br;
      logic [AW:0] tgt;
      wait_issue("rnd_issue");
      h  = half(exp_pc);
      ew = (h[15:11] == 5'b11110);
      ei = ew ? {h, half(exp_pc + 11'd1)} : {16'h0, h};
      check("rnd_instr", instr, ei);
      check("rnd_wide", instr_wide, ew);
      check("rnd_pc", pc, exp_pc);
      tick($urandom_range(0, 2));
      br  = ($urandom_range(0, 5) == 0);
      tgt = 11'($urandom);
      do_exec(br, tgt, 0);
      exp_ret = exp_ret + 32'd1;
      exp_pc  = br ? tgt : exp_pc + (ew ? 11'd2 : 11'd1);
      check("rnd_retired", retired, exp_ret);
    end
    wait_issue("rnd_last");
    do_exec(1, 11'h123, 1);
    check("rnd_halted", halted, 1);
    check("rnd_halt_pc", pc, exp_pc);
    check("rnd_halt_retired", retired, exp_ret + 32'd1);

    check("addr_stable", addr_bad, 0);
    check("req_valid_excl", excl_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
